line_encoder: RTL and testbench

//  Inverse of the puzzle-input line parser: serialises (row,col) tiles into ASCII "row,col\n" lines.

---
 rtl/line_codec_pkg.sv | 48 ++++
 rtl/bin_to_bcd.sv | 56 +++++
 rtl/line_encoder.sv | 185 ++++++++++++++++++
 tb/tb_line_encoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_codec_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_codec_pkg                                                           |
// | Shared character codes, digit sizing and encoder FSM states for the      |
// | "row,col" line codec. LINE_ENCODER_CRLF_EN adds the EMIT_CR state.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package line_codec_pkg;

    typedef enum logic [7:0] {
        NULL_CHAR = 8'h00,
        LF_CHAR   = 8'h0A,
        CR_CHAR   = 8'h0D,
        COMA_CHAR = 8'h2C,
        ZERO_CHAR = 8'h30,
        NINE_CHAR = 8'h39
    } char_t;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_CONV_ROW   = 4'd1,
        ST_EMIT_ROW   = 4'd2,
        ST_EMIT_COMMA = 4'd3,
        ST_CONV_COL   = 4'd4,
        ST_EMIT_COL   = 4'd5,
`ifdef LINE_ENCODER_CRLF_EN
        ST_EMIT_CR    = 4'd6,
`endif
        ST_EMIT_LF    = 4'd7,
        ST_EMIT_NUL   = 4'd8,
        ST_DONE       = 4'd9
    } enc_state_t;

    // Number of decimal digits in the largest value representable in 'bits' bits.
    function automatic int digits_for_bits(input int bits);
        longint unsigned v;
        int              n;
        v = (64'd1 << bits) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bin_to_bcd                                                               |
// | Sequential double-dabble: busy for exactly GRID_BITS cycles after start. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bin_to_bcd #(
    parameter int GRID_BITS = 17,
    parameter int DIGITS    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [GRID_BITS-1:0]  bin,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(GRID_BITS + 1);

    logic [GRID_BITS-1:0] r_shift;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [CNT_W-1:0]     r_cnt;
    logic [4*DIGITS-1:0]  w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else if (start) begin
            r_shift <= bin;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(GRID_BITS);
        end else if (r_cnt != '0) begin
            // DIGITS is sized for the full input range, so the dropped MSB is always zero.
            r_bcd   <= {w_adj[4*DIGITS-2:0], r_shift[GRID_BITS-1]};
            r_shift <= {r_shift[GRID_BITS-2:0], 1'b0};
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    assign busy = (r_cnt != '0);
    assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/line_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_encoder                                                             |
// | Serialises (row,col) tiles into ASCII "row,col\n" lines, NUL at EOF.     |
// | LINE_ENCODER_CRLF_EN: terminate lines with "\r\n" instead of "\n".       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module line_encoder
    import line_codec_pkg::*;
#(
    parameter int GRID_BITS = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tile_valid,
    output logic                 tile_ready,
    input  logic [GRID_BITS-1:0] tile_row,
    input  logic [GRID_BITS-1:0] tile_col,
    input  logic                 end_of_file,
    output logic                 outbound_valid,
    input  logic                 outbound_ready,
    output logic [7:0]           outbound_byte,
    output logic                 done
);

    localparam int DIGITS = digits_for_bits(GRID_BITS);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    enc_state_t           r_state;
    logic [GRID_BITS-1:0] r_col;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_tile_ready;
    logic                 r_out_valid;
    logic [7:0]           r_out_byte;
    logic                 r_done;
    logic                 r_eof_req;

    logic                 w_tile_hs;
    logic                 w_out_hs;
    logic                 w_eof;
    logic                 w_conv_start;
    logic                 w_conv_busy;
    logic [GRID_BITS-1:0] w_conv_bin;
    logic [4*DIGITS-1:0]  w_bcd;
    logic [IDX_W-1:0]     w_msd_idx;
    logic [IDX_W-1:0]     w_idx_dn;
    logic [7:0]           w_msd_byte;
    logic [7:0]           w_next_byte;

    assign w_tile_hs    = tile_valid && r_tile_ready;
    assign w_out_hs     = r_out_valid && outbound_ready;
    assign w_eof        = end_of_file || r_eof_req;
    // The converter is shared: loaded with the row on tile accept, with the column on comma accept.
    assign w_conv_start = w_tile_hs || ((r_state == ST_EMIT_COMMA) && w_out_hs);
    assign w_conv_bin   = w_tile_hs ? tile_row : r_col;

    bin_to_bcd #(
        .GRID_BITS (GRID_BITS),
        .DIGITS    (DIGITS)
    ) u_bin_to_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_conv_start),
        .bin   (w_conv_bin),
        .busy  (w_conv_busy),
        .bcd   (w_bcd)
    );

    // Most significant non-zero digit; an all-zero value still yields digit 0.
    always_comb begin
        w_msd_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_bcd[4*i +: 4] != 4'd0) begin
                w_msd_idx = IDX_W'(i);
            end
        end
    end

    assign w_idx_dn    = (r_idx == '0) ? '0 : r_idx - 1'b1;
    assign w_msd_byte  = 8'(ZERO_CHAR) + {4'd0, w_bcd[4*int'(w_msd_idx) +: 4]};
    assign w_next_byte = 8'(ZERO_CHAR) + {4'd0, w_bcd[4*int'(w_idx_dn) +: 4]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_idx        <= '0;
            r_tile_ready <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_byte   <= 8'h00;
            r_done       <= 1'b0;
            r_eof_req    <= 1'b0;
        end else begin
            if (end_of_file) begin
                r_eof_req <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    // An offered-and-ready tile is never dropped; EOF then follows its line.
                    if (w_tile_hs) begin
                        r_col        <= tile_col;
                        r_tile_ready <= 1'b0;
                        r_state      <= ST_CONV_ROW;
                    end else if (w_eof) begin
                        r_tile_ready <= 1'b0;
                        r_out_valid  <= 1'b1;
                        r_out_byte   <= 8'(NULL_CHAR);
                        r_state      <= ST_EMIT_NUL;
                    end else begin
                        r_tile_ready <= 1'b1;
                    end
                end
                ST_CONV_ROW, ST_CONV_COL: begin
                    if (!w_conv_busy) begin
                        r_out_valid <= 1'b1;
                        r_out_byte  <= w_msd_byte;
                        r_idx       <= w_msd_idx;
                        r_state     <= (r_state == ST_CONV_ROW) ? ST_EMIT_ROW : ST_EMIT_COL;
                    end
                end
                ST_EMIT_ROW, ST_EMIT_COL: begin
                    if (w_out_hs) begin
                        if (r_idx != '0) begin
                            r_idx      <= w_idx_dn;
                            r_out_byte <= w_next_byte;
                        end else if (r_state == ST_EMIT_ROW) begin
                            r_out_byte <= 8'(COMA_CHAR);
                            r_state    <= ST_EMIT_COMMA;
                        end else begin
`ifdef LINE_ENCODER_CRLF_EN
                            r_out_byte <= 8'(CR_CHAR);
                            r_state    <= ST_EMIT_CR;
`else
                            r_out_byte <= 8'(LF_CHAR);
                            r_state    <= ST_EMIT_LF;
`endif
                        end
                    end
                end
                ST_EMIT_COMMA: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_CONV_COL;
                    end
                end
`ifdef LINE_ENCODER_CRLF_EN
                ST_EMIT_CR: begin
                    if (w_out_hs) begin
                        r_out_byte <= 8'(LF_CHAR);
                        r_state    <= ST_EMIT_LF;
                    end
                end
`endif
                ST_EMIT_LF: begin
                    if (w_out_hs) begin
                        r_out_valid  <= 1'b0;
                        r_tile_ready <= !w_eof;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_EMIT_NUL: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_out_valid  <= 1'b0;
                    r_tile_ready <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tile_ready     = r_tile_ready;
    assign outbound_valid = r_out_valid;
    assign outbound_byte  = r_out_byte;
    assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_line_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_line_encoder                                                          |
// | Directed and random tiles; byte stream checked against a scoreboard.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_line_encoder;

    localparam int GB      = 17;
    localparam int MAXV    = (1 << GB) - 1;
    localparam int TIMEOUT = 5000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tile_valid = 1'b0;
    logic [GB-1:0] tile_row = '0;
    logic [GB-1:0] tile_col = '0;
    logic          end_of_file = 1'b0;
    logic          outbound_ready = 1'b0;
    logic          tile_ready;
    logic          outbound_valid;
    logic [7:0]    outbound_byte;
    logic          done;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         rx_count = 0;
    bit         mon_en = 1'b0;
    int         ready_mode = 0;
    int         pat_pos = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    bit         c_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    line_encoder #(.GRID_BITS(GB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tile_valid     (tile_valid),
        .tile_ready     (tile_ready),
        .tile_row       (tile_row),
        .tile_col       (tile_col),
        .end_of_file    (end_of_file),
        .outbound_valid (outbound_valid),
        .outbound_ready (outbound_ready),
        .outbound_byte  (outbound_byte),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Downstream ready: 0 = always, 1 = fixed stall pattern, 2 = random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: outbound_ready = 1'b1;
            1: begin
                outbound_ready = c_pat[pat_pos];
                pat_pos = (pat_pos + 1) % 6;
            end
            default: outbound_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Byte monitor: every transfer is popped from the scoreboard; stalled bytes must hold.
    always @(negedge clk) begin
        logic [7:0] want;
        if (mon_en) begin
            if (prev_stall) begin
                vectors++;
                assert (outbound_valid === 1'b1 && outbound_byte === prev_byte) else begin
                    miscompares++;
                    $error("FAIL hold: observed valid=%b byte=%h expected valid=1 byte=%h",
                           outbound_valid, outbound_byte, prev_byte);
                end
            end
            if (outbound_valid === 1'b1 && outbound_ready === 1'b1) begin
                vectors++;
                assert (exp_q.size() > 0) else begin
                    miscompares++;
                    $error("FAIL extra_byte: observed %h expected no byte", outbound_byte);
                end
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    vectors++;
                    assert (outbound_byte === want) else begin
                        miscompares++;
                        $error("FAIL byte: observed %h expected %h", outbound_byte, want);
                    end
                end
                rx_count++;
            end
            prev_stall = (outbound_valid === 1'b1 && outbound_ready !== 1'b1);
            prev_byte  = outbound_byte;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_line(input int r, input int c);
        string s;
        s = $sformatf("%0d,%0d", r, c);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`ifdef LINE_ENCODER_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
    endtask

    task automatic send_tile(input int r, input int c);
        int n;
        n = 0;
        push_line(r, c);
        tile_row   = GB'(r);
        tile_col   = GB'(c);
        tile_valid = 1'b1;
        while (tile_ready !== 1'b1 && n < TIMEOUT) begin
            tick();
            n++;
        end
        check("tile_accept_in_time", 32'(n < TIMEOUT), 32'd1);
        tick();
        tile_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || outbound_valid === 1'b1) && n < TIMEOUT) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        tick();
        tick();
        exp_q.delete();
        rst_n  = 1'b1;
        tick();
        mon_en = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int r;
        int c;

        // Reset values
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_tile_ready", 32'(tile_ready), 32'd0);
        check("rst_valid", 32'(outbound_valid), 32'd0);
        check("rst_byte", 32'(outbound_byte), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        // Tile (7,3) with first-digit latency
        ready_mode = 0;
        send_tile(7, 3);
        n = 0;
        while (outbound_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("first_digit_latency", 32'(n), 32'(GB + 1));
        drain("drain_7_3");
        tick();
        check("ready_after_line", 32'(tile_ready), 32'd1);
        check("idle_after_line", 32'(outbound_valid), 32'd0);

        // Zero fields and wide values
        send_tile(0, 0);
        drain("drain_0_0");
        send_tile(98765, 100000);
        send_tile(MAXV, 0);
        send_tile(MAXV, MAXV);
        drain("drain_wide");

        // Stall pattern
        ready_mode = 1;
        send_tile(12, 345);
        drain("drain_stall");
        ready_mode = 0;

        // Reset mid-line after "12" of row 123
        base = rx_count;
        send_tile(123, 9);
        n = 0;
        while (rx_count < base + 2 && n < 200) begin
            tick();
            n++;
        end
        check("two_bytes_before_reset", 32'(rx_count - base), 32'd2);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        tick();
        check("reset_aborts_valid", 32'(outbound_valid), 32'd0);
        check("reset_aborts_ready", 32'(tile_ready), 32'd0);
        exp_q.delete();
        rst_n  = 1'b1;
        tick();
        mon_en = 1'b1;
        send_tile(4, 5);
        drain("drain_after_reset");

        // end_of_file raised mid-line
        send_tile(21, 22);
        end_of_file = 1'b1;
        exp_q.push_back(8'h00);
        drain("drain_eof_midline");
        tick();
        check("done_after_midline_eof", 32'(done), 32'd1);
        end_of_file = 1'b0;
        tile_valid  = 1'b1;
        repeat (20) tick();
        tile_valid  = 1'b0;
        check("done_no_ready", 32'(tile_ready), 32'd0);
        check("done_no_valid", 32'(outbound_valid), 32'd0);
        check("done_sticky", 32'(done), 32'd1);

        // end_of_file in IDLE
        do_reset();
        end_of_file = 1'b1;
        exp_q.push_back(8'h00);
        drain("drain_eof_idle");
        repeat (20) tick();
        check("eof_idle_done", 32'(done), 32'd1);
        check("eof_idle_ready", 32'(tile_ready), 32'd0);
        check("eof_idle_valid", 32'(outbound_valid), 32'd0);
        end_of_file = 1'b0;

        // Random tiles with random backpressure
        do_reset();
        ready_mode = 2;
        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 3))
                0:       r = 0;
                1:       r = MAXV;
                default: r = int'($urandom_range(0, MAXV));
            endcase
            c = (k % 7 == 0) ? MAXV - r : int'($urandom_range(0, MAXV));
            send_tile(r, c);
        end
        drain("drain_random");
        check("random_done_low", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
